// File: rtl/aes128_enc_iter.sv
`timescale 1ns/1ps
// Iterative AES-128 encryption engine: one full cipher round per clock,
// round keys expanded on the fly, valid/ready handshakes on input and output.
module aes128_enc_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ROUND_W = 4;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Combinational S-box lookup.
  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] a);
    logic [10:0] idx;
    idx = 11'd2047 - {a, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t                fsm;
  logic [DATA_W-1:0]   state;
  logic [DATA_W-1:0]   rkey;
  logic [BYTE_W-1:0]   rcon;
  logic [ROUND_W-1:0]  round;

  logic [BYTE_W-1:0]   sb [16];
  logic [BYTE_W-1:0]   sr [16];
  logic [BYTE_W-1:0]   mc [16];
  logic [BYTE_W-1:0]   ks [4];
  logic [31:0]         t_word;
  logic [31:0]         w0n, w1n, w2n, w3n;
  logic [DATA_W-1:0]   next_key;
  logic [DATA_W-1:0]   round_out;
  logic                last_round;

  assign last_round = (round == ROUND_W'(NR));

  // SubBytes over the 16 state bytes, then ShiftRows as pure wiring.
  for (genvar k = 0; k < 16; k++) begin : g_sub_shift
    assign sb[k] = sbox(state[127-8*k -: 8]);
    assign sr[k] = sb[4*(((k/4) + (k%4)) % 4) + (k%4)];
  end

  // MixColumns on each column of the shifted state.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Key schedule: SubWord(RotWord(w3)) through the four key-side S-boxes.
  assign ks[0]  = sbox(rkey[23:16]);
  assign ks[1]  = sbox(rkey[15:8]);
  assign ks[2]  = sbox(rkey[7:0]);
  assign ks[3]  = sbox(rkey[31:24]);
  assign t_word = {ks[0] ^ rcon, ks[1], ks[2], ks[3]};
  assign w0n    = rkey[127:96] ^ t_word;
  assign w1n    = rkey[95:64]  ^ w0n;
  assign w2n    = rkey[63:32]  ^ w1n;
  assign w3n    = rkey[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  // AddRoundKey; the final round bypasses MixColumns.
  for (genvar k = 0; k < 16; k++) begin : g_ark
    assign round_out[127-8*k -: 8] = (last_round ? sr[k] : mc[k]) ^ next_key[127-8*k -: 8];
  end

  // Handshake flags are straight decodes of the state register.
  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign out_data  = state;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      state <= '0;
      rkey  <= '0;
      rcon  <= '0;
      round <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state <= in_data ^ in_key;
            rkey  <= in_key;
            rcon  <= 8'h01;
            round <= ROUND_W'(1);
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          state <= round_out;
          rkey  <= next_key;
          rcon  <= xtime(rcon);
          round <= round + ROUND_W'(1);
          if (last_round) begin
            fsm <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
